// File: rtl/univ_shift_reg.sv
// Universal shift register with a burst sequencer.
// A WIDTH-bit register supports synchronous clear, set and parallel load.
// It shifts by STEP bits in one of four modes: logical left, logical right,
// rotate left or arithmetic right.
// A start/busy/done sequencer runs a burst of `count` shifts.
// The sequencer state is exposed on dbg_state (00 IDLE, 01 RUN, 10 DONE).
//
// Burst handshake: a request is taken only in IDLE, on an enabled edge
// where start=1 and no sclr/sset/load is asserted. On that edge, mode and
// count are captured. busy stays high for exactly the shift edges. done
// is a single-cycle pulse after the last shift, or straight after a
// zero-length request. start is ignored while busy or done is high. A
// clear, set or load during RUN ends the burst without a done pulse.
module univ_shift_reg #(
    parameter int WIDTH       = 8,
    parameter int STEP        = 1,
    parameter int CNT_W       = 4,
    parameter int RST_VALUE   = 2,
    parameter int LOAD_SVALUE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             sclr,
    input  logic             sset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic [STEP-1:0]  shiftin,
    input  logic [1:0]       mode,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q,
    output logic [STEP-1:0]  shiftout,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

    localparam logic [WIDTH-1:0] RST_Q  = WIDTH'(RST_VALUE);
    localparam logic [WIDTH-1:0] SSET_Q = WIDTH'(LOAD_SVALUE);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   remaining_q, remaining_d;
    logic [1:0]         mode_r_q, mode_r_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [WIDTH-1:0]   shifted;
    logic               any_ld;

    assign any_ld = sclr | sset | load;

    // One STEP-bit shift of the current contents according to the latched mode.
    always_comb begin
        shifted = q_q;
        case (mode_r_q)
            2'b00:   shifted = {q_q[WIDTH-1-STEP:0], shiftin};
            2'b01:   shifted = {shiftin, q_q[WIDTH-1:STEP]};
            2'b10:   shifted = {q_q[WIDTH-1-STEP:0], q_q[WIDTH-1:WIDTH-STEP]};
            default: shifted = {{STEP{q_q[WIDTH-1]}}, q_q[WIDTH-1:STEP]};
        endcase
    end

    // Next-state logic: sclr > sset > load > sequencer. Everything is gated by enable except DONE->IDLE.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        mode_r_d    = mode_r_q;
        q_d         = q_q;
        if (enable) begin
            if (any_ld) begin
                if (sclr) begin
                    q_d = '0;
                end else if (sset) begin
                    q_d = SSET_Q;
                end else begin
                    q_d = data;
                end
                // A register write always leaves the sequencer idle, and silently aborts a running burst.
                state_d     = ST_IDLE;
                remaining_d = '0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start) begin
                            if (count != '0) begin
                                mode_r_d    = mode;
                                remaining_d = count;
                                state_d     = ST_RUN;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                    ST_RUN: begin
                        q_d         = shifted;
                        remaining_d = remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end
        end else if (state_q == ST_DONE) begin
            state_d = ST_IDLE;
        end
    end

    // State, counter, latched mode and data registers with async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            mode_r_q    <= 2'b00;
            q_q         <= RST_Q;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            mode_r_q    <= mode_r_d;
            q_q         <= q_d;
        end
    end

    // Outputs are decoded from registered state.
    // Left-moving modes expose the top STEP bits, right-moving modes expose the bottom STEP bits.
    always_comb begin
        busy      = (state_q == ST_RUN);
        done      = (state_q == ST_DONE);
        q         = q_q;
        dbg_state = state_q;
        shiftout  = mode_r_q[0] ? q_q[STEP-1:0] : q_q[WIDTH-1:WIDTH-STEP];
    end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg (defaults WIDTH=8, STEP=1, CNT_W=4).
module tb_univ_shift_reg;

    localparam int W  = 8;
    localparam int S  = 1;
    localparam int CW = 4;
    localparam int EW = W + 2 + S;

    localparam int P_IDLE = 0;
    localparam int P_RUN  = 1;
    localparam int P_DONE = 2;

    // ---------------- clock / reset and DUT signals ----------------
    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          enable  = 1'b1;
    logic          sclr    = 1'b0;
    logic          sset    = 1'b0;
    logic          load    = 1'b0;
    logic          start   = 1'b0;
    logic [W-1:0]  data    = '0;
    logic [S-1:0]  shiftin = '0;
    logic [1:0]    mode    = '0;
    logic [CW-1:0] count   = '0;
    logic          busy;
    logic          done;
    logic [W-1:0]  q;
    logic [S-1:0]  shiftout;
    logic [1:0]    dbg_state;

    always #5 clk = ~clk;

    univ_shift_reg #(
        .WIDTH(W), .STEP(S), .CNT_W(CW), .RST_VALUE(2), .LOAD_SVALUE(4)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .sclr(sclr), .sset(sset),
        .load(load), .data(data), .shiftin(shiftin), .mode(mode),
        .start(start), .count(count), .busy(busy), .done(done), .q(q),
        .shiftout(shiftout), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int total = 0;
    int bad   = 0;
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] mon_exp;
    logic [EW-1:0] mon_got;

    // ---------------- behavioural reference model ----------------
    logic [W-1:0] m_q;
    int           m_phase;
    int           m_rem;
    logic [1:0]   m_mode;

    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] v, input logic [1:0] md,
                                                input logic [S-1:0] si);
        int unsigned x;
        int unsigned fill;
        logic signed [W-1:0] sv;
        x    = v;
        fill = si;
        sv   = v;
        case (md)
            2'd0:    return W'((x << S) | fill);
            2'd1:    return W'((x >> S) | (fill << (W - S)));
            2'd2:    return W'((x << S) | (x >> (W - S)));
            default: return W'(sv >>> S);
        endcase
    endfunction

    function automatic logic [S-1:0] ref_out(input logic [W-1:0] v, input logic [1:0] md);
        int unsigned x;
        x = v;
        if (md == 2'd0 || md == 2'd2) return S'(x >> (W - S));
        return S'(x % (1 << S));
    endfunction

    function automatic logic [EW-1:0] snapshot();
        return {m_q, (m_phase == P_RUN), (m_phase == P_DONE), ref_out(m_q, m_mode)};
    endfunction

    task automatic model_reset();
        m_q     = 8'h02;
        m_phase = P_IDLE;
        m_rem   = 0;
        m_mode  = 2'd0;
    endtask

    // Effect of one rising edge given the inputs currently driven.
    task automatic model_step();
        if (!rst_n) begin
            model_reset();
        end else if (!enable) begin
            if (m_phase == P_DONE) m_phase = P_IDLE;
        end else if (sclr || sset || load) begin
            m_q     = sclr ? 8'h00 : (sset ? 8'h04 : data);
            m_phase = P_IDLE;
            m_rem   = 0;
        end else if (m_phase == P_IDLE) begin
            if (start) begin
                if (count != 0) begin
                    m_mode  = mode;
                    m_rem   = int'(count);
                    m_phase = P_RUN;
                end else begin
                    m_phase = P_DONE;
                end
            end
        end else if (m_phase == P_RUN) begin
            m_q   = ref_shift(m_q, m_mode, shiftin);
            m_rem = m_rem - 1;
            if (m_rem == 0) m_phase = P_DONE;
        end else begin
            m_phase = P_IDLE;
        end
    endtask

    // ---------------- driver tasks ----------------
    // Predict the outcome of the coming edge, queue it, and advance to the next falling edge.
    task automatic tick();
        model_step();
        exp_q.push_back(snapshot());
        @(negedge clk);
    endtask

    task automatic quiet();
        enable = 1'b1; sclr = 1'b0; sset = 1'b0; load = 1'b0; start = 1'b0;
    endtask

    task automatic do_load(input logic [W-1:0] v);
        quiet();
        load = 1'b1; data = v;
        tick();
        load = 1'b0;
    endtask

    task automatic do_start(input logic [1:0] md, input logic [CW-1:0] n, input logic [S-1:0] si);
        quiet();
        mode = md; count = n; shiftin = si; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            mon_got = {q, busy, done, shiftout};
            total++;
            if (mon_got !== mon_exp) begin
                bad++;
                $display("FAIL cycle_state t=%0t got q/busy/done/so=%h want=%h", $time, mon_got, mon_exp);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: stimulus did not complete");
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        tick();
        tick();
        check("reset_q", q, 8'h02);
        check("reset_busy", busy, 0);

        // Async reset in the middle of a burst
        rst_n = 1'b1;
        do_load(8'h55);
        do_start(2'd0, 4'd5, 1'b0);
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_q", q, 8'h02);
        check("async_rst_busy", busy, 0);
        check("async_rst_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("post_rst_q", q, 8'h02);

        // Logical-left burst of three
        do_load(8'hA5);
        do_start(2'd0, 4'd3, 1'b1);
        check("ll_busy_start", busy, 1);
        tick();
        check("ll_shift1", q, 8'h4B);
        tick();
        check("ll_shift2", q, 8'h97);
        tick();
        check("ll_shift3", q, 8'h2F);
        check("ll_done", done, 1);
        tick();
        check("ll_done_clear", done, 0);
        check("ll_idle_busy", busy, 0);

        // Rotate left and arithmetic right
        do_load(8'h81);
        do_start(2'd2, 4'd1, 1'b0);
        tick();
        check("rol_q", q, 8'h03);
        check("rol_shiftout", shiftout, 0);
        tick();
        do_load(8'h80);
        do_start(2'd3, 4'd3, 1'b0);
        tick();
        tick();
        tick();
        check("asr_q", q, 8'hF0);
        tick();

        // Enable stall in the middle of a right burst
        do_load(8'hF0);
        do_start(2'd1, 4'd4, 1'b0);
        tick();
        tick();
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_q", q, 8'h3C);
            check("stall_busy", busy, 1);
        end
        enable = 1'b1;
        tick();
        tick();
        check("stall_resume_q", q, 8'h0F);
        check("stall_done", done, 1);
        tick();
        check("stall_done_once", done, 0);

        // Abort with sclr on the second shift edge
        do_load(8'h5A);
        do_start(2'd0, 4'd5, 1'b0);
        tick();
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check("abort_q", q, 8'h00);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        do_start(2'd0, 4'd1, 1'b0);
        check("restart_busy", busy, 1);
        tick();
        tick();

        // Zero-length request, then start held high through a burst
        do_load(8'h3C);
        do_start(2'd0, 4'd0, 1'b0);
        check("zero_done", done, 1);
        check("zero_busy", busy, 0);
        check("zero_q", q, 8'h3C);
        tick();
        check("zero_done_once", done, 0);
        do_start(2'd0, 4'd2, 1'b1);
        start = 1'b1;
        count = 4'd7;
        tick();
        tick();
        check("hold_start_done", done, 1);
        check("hold_start_q", q, 8'hF3);
        tick();
        check("hold_start_idle", busy, 0);
        start = 1'b0;
        tick();

        // Randomised traffic
        for (int i = 0; i < 500; i++) begin
            enable  = ($urandom_range(0, 9) < 8);
            sclr    = ($urandom_range(0, 40) == 0);
            sset    = ($urandom_range(0, 40) == 0);
            load    = ($urandom_range(0, 15) == 0);
            start   = ($urandom_range(0, 3) == 0);
            data    = W'($urandom_range(0, 255));
            shiftin = S'($urandom_range(0, 1));
            mode    = 2'($urandom_range(0, 3));
            count   = ($urandom_range(0, 7) == 0) ? 4'd0 : CW'($urandom_range(1, 15));
            tick();
        end
        quiet();
        for (int i = 0; i < 20; i++) tick();

        #1;
        check("queue_drain", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
